dual_rail_receiver: RTL

DUAL_RAIL_RECEIVER -- requirements
Module: dual_rail_receiver

---
 rtl/dual_rail_receiver_if.sv | 25 ++
 rtl/dual_rail_receiver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dual_rail_receiver_if.sv
// rtl/dual_rail_receiver_if.sv - dual-rail receiver line and result bundle
interface dual_rail_receiver_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 4
);
  logic             F;
  logic             G;
  logic             SAMPLE;
  logic             CLR_ERR;
  logic [WIDTH-1:0] DATA;
  logic             DATA_VALID;
  logic             ERR;
  logic [1:0]       ERR_CODE;
  logic [ERR_W-1:0] ERR_COUNT;

  modport master (
    output F, G, SAMPLE, CLR_ERR,
    input  DATA, DATA_VALID, ERR, ERR_CODE, ERR_COUNT
  );

  modport slave (
    input  F, G, SAMPLE, CLR_ERR,
    output DATA, DATA_VALID, ERR, ERR_CODE, ERR_COUNT
  );
endinterface

// File: rtl/dual_rail_receiver.sv
// rtl/dual_rail_receiver.sv - dual-rail return-to-null word receiver with error tracking
module dual_rail_receiver #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 4
) (
  input logic               CLK1,
  input logic               RST,
  dual_rail_receiver_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_SPACER  = 2'b10;

  typedef enum logic [1:0] {
    EXP_DATA = 2'd0,
    EXP_NULL = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] data_n;
  logic             dv_n;
  logic             err_n;
  logic [1:0]       code_n;
  logic [ERR_W-1:0] errcnt_n;

  logic             is_data;
  logic             is_null;
  logic             is_ill;
  logic [WIDTH-1:0] shifted;

  // Classify the codeword on the rails and form the shifted partial word.
  always_comb begin
    is_data = bus.F ^ bus.G;
    is_null = ~bus.F & ~bus.G;
    is_ill  = bus.F & bus.G;
    shifted = {shreg[WIDTH-2:0], bus.F};
  end

  // Next-state and next-output decode; nothing moves unless SAMPLE qualifies the edge.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    cnt_n    = cnt;
    data_n   = bus.DATA;
    dv_n     = 1'b0;
    err_n    = 1'b0;
    code_n   = bus.ERR_CODE;
    errcnt_n = bus.ERR_COUNT;

    if (bus.SAMPLE) begin
      if (is_ill) begin
        // Illegal codeword is an error from every state, including ERROR itself.
        err_n   = 1'b1;
        code_n  = CODE_ILLEGAL;
        state_n = ERROR;
        shreg_n = '0;
        cnt_n   = '0;
      end else begin
        unique case (state)
          EXP_DATA: begin
            if (is_data) begin
              state_n = EXP_NULL;
              if (cnt == LAST_BIT) begin
                data_n  = shifted;
                dv_n    = 1'b1;
                shreg_n = '0;
                cnt_n   = '0;
              end else begin
                shreg_n = shifted;
                cnt_n   = cnt + 1'b1;
              end
            end
          end
          EXP_NULL: begin
            if (is_null) begin
              state_n = EXP_DATA;
            end else if (is_data) begin
              err_n   = 1'b1;
              code_n  = CODE_SPACER;
              state_n = ERROR;
              shreg_n = '0;
              cnt_n   = '0;
            end
          end
          ERROR: begin
            // Data while recovering is ignored; only a spacer re-arms the receiver.
            if (is_null) begin
              state_n = EXP_DATA;
            end
          end
          default: begin
            state_n = EXP_DATA;
            shreg_n = '0;
            cnt_n   = '0;
          end
        endcase
      end
    end

    if (err_n && (bus.ERR_COUNT != ERR_MAX)) begin
      errcnt_n = bus.ERR_COUNT + 1'b1;
    end
    // Clear takes priority over a coincident increment.
    if (bus.CLR_ERR) begin
      errcnt_n = '0;
    end
  end

  // State and registered outputs, asynchronously cleared by RST.
  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      state         <= EXP_DATA;
      shreg         <= '0;
      cnt           <= '0;
      bus.DATA       <= '0;
      bus.DATA_VALID <= 1'b0;
      bus.ERR        <= 1'b0;
      bus.ERR_CODE   <= 2'b00;
      bus.ERR_COUNT  <= '0;
    end else begin
      state         <= state_n;
      shreg         <= shreg_n;
      cnt           <= cnt_n;
      bus.DATA       <= data_n;
      bus.DATA_VALID <= dv_n;
      bus.ERR        <= err_n;
      bus.ERR_CODE   <= code_n;
      bus.ERR_COUNT  <= errcnt_n;
    end
  end

endmodule
